// File: rtl/addsub_serial.sv
// Digit-serial add/subtract, DIGIT bits per cycle, carry registered between slices.
// Define ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
            $error("addsub_serial: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ofl_q, ofl_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [DIGIT-1:0] sl_a, sl_b;
    logic [DIGIT:0]   sl_sum;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ofl       = ofl_q;
    assign zero      = zero_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ofl_d   = ofl_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        sl_a    = '0;
        sl_b    = '0;

        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                sl_a = opa_q[k*DIGIT +: DIGIT];
                sl_b = opb_q[k*DIGIT +: DIGIT];
            end
        end
        sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{DIGIT{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    opa_d   = a;
                    opb_d   = b ^ {WIDTH{opcode}};
                    carry_d = opcode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        work_d[k*DIGIT +: DIGIT] = sl_sum[DIGIT-1:0];
                    end
                end
                carry_d = sl_sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    valid_d = 1'b1;
                    cout_d  = sl_sum[DIGIT];
                    ofl_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (work_d[WIDTH-1] != opa_q[WIDTH-1]);
                    sum_d   = work_d;
`ifdef ADDSUB_SAT_EN
                    // Overflow direction follows the sign shared by both operands
                    if (ofl_d) begin
                        sum_d = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    zero_d  = (sum_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ofl_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ofl_q   <= ofl_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

endmodule
